// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M execution unit.
// A multiply is held for MUL_STAGES cycles before its result is registered.
// A divide runs an iterative restoring divider that produces one quotient bit
// per cycle, then applies the operand signs in a separate fix-up cycle.
// The busy/done handshake lets the core's hazard logic stall the EX stage.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request; taken only while busy=0 (IDLE or DONE)
//   funct3          M-extension operation select (mul..remu)
//   op_a, op_b      rs1/dividend and rs2/divisor, latched on accept
//   flush           synchronous abort; has priority over start
//   busy            high while an operation is in flight (MUL, DIV, FIX)
//   done            one-cycle pulse; result and div_zero are valid
//   result          operation result; updated only when an operation completes
//   div_zero        set for a div/rem whose divisor was zero
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam int CNT_W = $clog2(((XLEN > MUL_STAGES) ? XLEN : MUL_STAGES) + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STAGES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              quot_neg_q, quot_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              div_zero_q, div_zero_d;

  logic              a_signed, b_signed;
  logic [2*XLEN-1:0] mul_a_wide, mul_b_wide, product;
  logic [XLEN:0]     trial;
  logic              a_neg, b_neg;

  // State register. Everything returns to zero on reset so no stale result
  // or div_zero flag survives a reset in the middle of an operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Datapath helpers shared by the FSM. The multiply sign-extends each operand
  // to 2*XLEN so a plain unsigned product yields the right two's-complement
  // bits for every signedness mix. The divider compares the partial remainder
  // with the next dividend bit shifted in against the divisor; the top bit of
  // the difference is the borrow.
  always_comb begin
    a_signed   = (op_q != 2'b11);
    b_signed   = ~op_q[1];
    mul_a_wide = {{XLEN{a_signed & a_q[XLEN-1]}}, a_q};
    mul_b_wide = {{XLEN{b_signed & b_q[XLEN-1]}}, b_q};
    product    = mul_a_wide * mul_b_wide;
    trial      = {rem_q, a_q[XLEN-1]} - {1'b0, b_q};
  end

  // Next-state and datapath update. During a divide, a_q holds the shifting
  // dividend/quotient. Divide special cases are resolved on acceptance.
  // They still pass through FIX, so every divide-class result is registered
  // at the same point.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    a_neg      = 1'b0;
    b_neg      = 1'b0;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            op_d       = funct3[1:0];
            div_zero_d = 1'b0;
            if (!funct3[2]) begin
              a_d     = op_a;
              b_d     = op_b;
              cnt_d   = MUL_LAST;
              state_d = MUL;
            end else begin
              a_neg      = ~funct3[0] & op_a[XLEN-1];
              b_neg      = ~funct3[0] & op_b[XLEN-1];
              quot_neg_d = 1'b0;
              rem_neg_d  = 1'b0;
              cnt_d      = DIV_LAST;
              state_d    = FIX;
              // Special cases load the final quotient into a_q and the final
              // remainder into rem_q with no sign fix-up pending.
              if (op_b == '0) begin
                a_d        = '1;
                rem_d      = op_a;
                div_zero_d = 1'b1;
              end else if (~funct3[0] && (op_a == MIN_NEG) && (op_b == '1)) begin
                a_d   = op_a;
                rem_d = '0;
              end else begin
                a_d        = a_neg ? -op_a : op_a;
                b_d        = b_neg ? -op_b : op_b;
                rem_d      = '0;
                quot_neg_d = a_neg ^ b_neg;
                rem_neg_d  = a_neg;
                state_d    = DIV;
              end
            end
          end
        end

        MUL: begin
          if (cnt_q == '0) begin
            result_d = (op_q == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        DIV: begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = {rem_q[XLEN-2:0], a_q[XLEN-1]};
            a_d   = {a_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end

        FIX: begin
          if (op_q[1]) begin
            result_d = rem_neg_q ? -rem_q : rem_q;
          end else begin
            result_d = quot_neg_q ? -a_q : a_q;
          end
          state_d = DONE;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign busy     = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (XLEN=32,
// MUL_STAGES=2). Each step drives an operation, waits a bounded number of
// cycles for done, and compares the latency, result and div_zero against
// hand-computed constants. Latency counts the rising edges after the accept
// edge until done is seen high.
module tb_muldiv_unit;

  localparam int XLEN       = 32;
  localparam int MUL_STAGES = 2;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam int MUL_LAT  = MUL_STAGES;
  localparam int DIV_LAT  = XLEN + 1;
  localparam int SPEC_LAT = 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            div_zero;

  int testCount = 0;
  int failCount = 0;
  int lat;
  int doneSeen;

  muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .div_zero(div_zero)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog: stop a hung run with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (the accept edge), then scramble the
  // inputs to show the operands were latched.
  task automatic applyStimulus(input logic [2:0] f, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    stepCycle();
    start  = 1'b0;
    funct3 = ~f;
    op_a   = ~a;
    op_b   = ~b;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 200) begin
      stepCycle();
      cycles++;
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [2:0] f,
                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [XLEN-1:0] expRes, input int expLat,
                             input logic expDz);
    int cycles;
    applyStimulus(f, a, b);
    checkOutput({tag, " busy after accept"}, XLEN'(busy), XLEN'(1'b1));
    waitDone(cycles);
    checkOutput({tag, " latency"}, XLEN'(cycles), XLEN'(expLat));
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " div_zero"}, XLEN'(div_zero), XLEN'(expDz));
    stepCycle();
    checkOutput({tag, " done one cycle"}, XLEN'(done), XLEN'(1'b0));
    checkOutput({tag, " result held"}, result, expRes);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", XLEN'(busy), '0);
    checkOutput("reset done", XLEN'(done), '0);
    checkOutput("reset result", result, '0);
    checkOutput("reset div_zero", XLEN'(div_zero), '0);
    rst = 1'b0;
    stepCycle();

    // Multiply variants.
    runAndCheck("mul 7*-3", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
    runAndCheck("mulh min*min", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 1'b0);
    runAndCheck("mulhsu -1*max", F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
    runAndCheck("mulhu max*max", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b0);

    // Divide special cases, resolved on acceptance.
    runAndCheck("div 5/0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT, 1'b1);
    runAndCheck("rem 5/0", F_REM, 32'd5, 32'd0, 32'd5, SPEC_LAT, 1'b1);
    runAndCheck("remu 9/0", F_REMU, 32'd9, 32'd0, 32'd9, SPEC_LAT, 1'b1);
    runAndCheck("div overflow", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, 1'b0);
    runAndCheck("rem overflow", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT, 1'b0);

    // Normal divides through the iterative path.
    runAndCheck("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
    runAndCheck("rem -7/2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
    runAndCheck("div 7/-2", F_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
    runAndCheck("rem 7/-2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, DIV_LAT, 1'b0);
    runAndCheck("divu 100/7", F_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, 1'b0);
    runAndCheck("remu 100/7", F_REMU, 32'd100, 32'd7, 32'd2, DIV_LAT, 1'b0);

    // Flush during iteration 10 of a divu: back to IDLE, no done, result kept.
    applyStimulus(F_DIVU, 32'd1000, 32'd3);
    repeat (10) stepCycle();
    checkOutput("flush busy before", XLEN'(busy), XLEN'(1'b1));
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("flush busy after", XLEN'(busy), '0);
    checkOutput("flush done after", XLEN'(done), '0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) doneSeen++;
      stepCycle();
    end
    checkOutput("flush no done pulse", XLEN'(doneSeen), '0);
    checkOutput("flush result kept", result, 32'd2);

    // A start while busy is dropped, not queued.
    applyStimulus(F_DIVU, 32'd50, 32'd5);
    repeat (5) stepCycle();
    start  = 1'b1;
    funct3 = F_MUL;
    op_a   = 32'd3;
    op_b   = 32'd4;
    stepCycle();
    start  = 1'b0;
    waitDone(lat);
    checkOutput("busy start latency", XLEN'(lat), XLEN'(DIV_LAT - 6));
    checkOutput("busy start result", result, 32'd10);
    stepCycle();
    checkOutput("busy start not queued", XLEN'(busy), '0);
    repeat (3) stepCycle();
    checkOutput("busy start idle done", XLEN'(done), '0);

    // Back-to-back: a new start in the DONE cycle is accepted with no bubble.
    applyStimulus(F_MUL, 32'd6, 32'd7);
    waitDone(lat);
    checkOutput("b2b first latency", XLEN'(lat), XLEN'(MUL_LAT));
    checkOutput("b2b first result", result, 32'd42);
    applyStimulus(F_MULHU, 32'hFFFF_FFFF, 32'd2);
    checkOutput("b2b no bubble busy", XLEN'(busy), XLEN'(1'b1));
    checkOutput("b2b no bubble done", XLEN'(done), '0);
    waitDone(lat);
    checkOutput("b2b second latency", XLEN'(lat), XLEN'(MUL_LAT));
    checkOutput("b2b second result", result, 32'd1);
    stepCycle();

    // Asynchronous reset in the middle of a divide clears outputs at once.
    applyStimulus(F_DIV, 32'd1000, 32'd7);
    repeat (5) stepCycle();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async rst busy", XLEN'(busy), '0);
    checkOutput("async rst done", XLEN'(done), '0);
    checkOutput("async rst result", result, '0);
    checkOutput("async rst div_zero", XLEN'(div_zero), '0);
    repeat (2) stepCycle();
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) doneSeen++;
      stepCycle();
    end
    checkOutput("async rst no done pulse", XLEN'(doneSeen), '0);
    checkOutput("async rst stays idle", XLEN'(busy), '0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
